stopwatch_core: RTL and testbench

- Stopwatch datapath plus control: prescaler, four cascaded BCD digits (MM:SS, 00:00 to 59:59), run/pause/clear FSM and lap-freeze display register.
- Consumes T-flip-flop excitation per digit. Each digit is a T-type register whose toggle vector is derived from its present state and modulus, gated by the cascade enable.
- Sits directly downstream of the per-digit up-count excitation logic and directly upstream of the seven-segment display drivers.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/bcd_digit_tff.sv | 35 +++
 rtl/stopwatch_core.sv | 117 +++++++++++
 tb/tb_stopwatch_core.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch: FSM encoding and
// BCD digit widths/terminal counts.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam int BCD_W        = 4;
   localparam int SEC_ONES_MAX = 9;
   localparam int SEC_TENS_MAX = 5;
   localparam int MIN_ONES_MAX = 9;
   localparam int MIN_TENS_MAX = 5;

endpackage

// File: rtl/bcd_digit_tff.sv
// One BCD digit held in a T-type register counting 0..MAX; the toggle vector
// is the XOR of the present state and its successor, gated by en.
module bcd_digit_tff
   import stopwatch_pkg::*;
#(
   parameter int MAX = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   output logic [BCD_W-1:0] q,
   output logic             tc
);

   logic [BCD_W-1:0] succ;
   logic [BCD_W-1:0] t;

   // Out-of-range codes fall back to 0 so the digit can never stick above MAX.
   always_comb begin
      succ = (q >= BCD_W'(MAX)) ? '0 : q + BCD_W'(1);
      t    = en ? (q ^ succ) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         q <= '0;
      end else begin
         q <= q ^ t;
      end
   end

   assign tc = (q == BCD_W'(MAX));

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch control and datapath: run/pause/clear FSM, 1 s prescaler, four
// cascaded BCD digits (MM:SS) and a lap-freeze display register.
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_stop,
   input  logic             clear,
   input  logic             lap,
   output logic [BCD_W-1:0] sec_ones,
   output logic [BCD_W-1:0] sec_tens,
   output logic [BCD_W-1:0] min_ones,
   output logic [BCD_W-1:0] min_tens,
   output logic             running,
   output logic             frozen,
   output logic             wrap
);

   localparam int             PW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PS_LAST = PW'(TICK_DIV - 1);

   // state is the observable FSM register for external checkers.
   state_t           state;
   state_t           state_nxt;
   logic             frozen_nxt;
   logic             zero_all;
   logic [PW-1:0]    prescaler;
   logic             tick;
   logic [3:0]       en;
   logic [3:0]       tc;
   logic [BCD_W-1:0] q_so, q_st, q_mo, q_mt;

   always_comb begin
      state_nxt  = state;
      frozen_nxt = frozen;
      case (state)
         IDLE:    if (start_stop && !clear) state_nxt = RUN;
         RUN:     if (clear) state_nxt = IDLE; else if (start_stop) state_nxt = PAUSE;
         PAUSE:   if (clear) state_nxt = IDLE; else if (start_stop) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
      // A lap pulse freezes only while running; in PAUSE it can only release.
      if (state_nxt == IDLE) begin
         frozen_nxt = 1'b0;
      end else if (lap) begin
         if (state == RUN) begin
            frozen_nxt = !frozen;
         end else if (state == PAUSE) begin
            frozen_nxt = 1'b0;
         end
      end
   end

   assign zero_all = (state_nxt == IDLE);
   assign tick     = (state == RUN) && (prescaler == PS_LAST);

   assign en[0] = tick;
   assign en[1] = en[0] & tc[0];
   assign en[2] = en[1] & tc[1];
   assign en[3] = en[2] & tc[2];

   bcd_digit_tff #(.MAX(SEC_ONES_MAX)) u_sec_ones (
      .clk(clk), .rst_n(rst_n), .en(en[0]), .clr(zero_all), .q(q_so), .tc(tc[0])
   );
   bcd_digit_tff #(.MAX(SEC_TENS_MAX)) u_sec_tens (
      .clk(clk), .rst_n(rst_n), .en(en[1]), .clr(zero_all), .q(q_st), .tc(tc[1])
   );
   bcd_digit_tff #(.MAX(MIN_ONES_MAX)) u_min_ones (
      .clk(clk), .rst_n(rst_n), .en(en[2]), .clr(zero_all), .q(q_mo), .tc(tc[2])
   );
   bcd_digit_tff #(.MAX(MIN_TENS_MAX)) u_min_tens (
      .clk(clk), .rst_n(rst_n), .en(en[3]), .clr(zero_all), .q(q_mt), .tc(tc[3])
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         prescaler <= '0;
         running   <= 1'b0;
         frozen    <= 1'b0;
         wrap      <= 1'b0;
         sec_ones  <= '0;
         sec_tens  <= '0;
         min_ones  <= '0;
         min_tens  <= '0;
      end else begin
         state   <= state_nxt;
         running <= (state_nxt == RUN);
         frozen  <= frozen_nxt;
         wrap    <= en[3] & tc[3] & !zero_all;

         // Prescaler holds in PAUSE so the fractional second survives a pause.
         if (zero_all || tick) begin
            prescaler <= '0;
         end else if (state == RUN) begin
            prescaler <= prescaler + PW'(1);
         end

         // The display keeps its current value on the edge that freezes it.
         if (zero_all) begin
            sec_ones <= '0;
            sec_tens <= '0;
            min_ones <= '0;
            min_tens <= '0;
         end else if (!frozen_nxt) begin
            sec_ones <= q_so;
            sec_tens <= q_st;
            min_ones <= q_mo;
            min_tens <= q_mt;
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with TICK_DIV=4; display values are
// compared as packed BCD {min_tens,min_ones,sec_tens,sec_ones}.
module tb_stopwatch_core;

   localparam int TICK_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_stop = 1'b0;
   logic       clear = 1'b0;
   logic       lap = 1'b0;
   logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
   logic       running, frozen, wrap;
   logic [15:0] disp;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   stopwatch_core #(.TICK_DIV(TICK_DIV)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start_stop(start_stop),
      .clear(clear),
      .lap(lap),
      .sec_ones(sec_ones),
      .sec_tens(sec_tens),
      .min_ones(min_ones),
      .min_tens(min_tens),
      .running(running),
      .frozen(frozen),
      .wrap(wrap)
   );

   assign disp = {min_tens, min_ones, sec_tens, sec_ones};

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start_stop = 1'b1;
      @(negedge clk);
      start_stop = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1;
      @(negedge clk);
      lap = 1'b0;
   endtask

   initial begin
      // reset
      cycles(2);
      rst_n = 1'b1;
      chk("rst_disp", disp, 16'h0000);
      chk("rst_running", {15'd0, running}, 16'd0);
      chk("rst_frozen", {15'd0, frozen}, 16'd0);
      chk("rst_wrap", {15'd0, wrap}, 16'd0);

      // basic counting: ticks at RUN edges 4, 8, ..., display one cycle later
      pulse_start();
      chk("start_running", {15'd0, running}, 16'd1);
      chk("start_disp", disp, 16'h0000);
      cycles(4);
      chk("tick1_latency", disp, 16'h0000);
      cycles(1);
      chk("tick1_disp", disp, 16'h0001);
      cycles(4);
      chk("tick2_disp", disp, 16'h0002);
      cycles(31);
      chk("tick9_disp", disp, 16'h0009);
      cycles(1);
      chk("tick10_carry", disp, 16'h0010);

      // clear from RUN, then IDLE does not count
      pulse_clear();
      chk("clear_disp", disp, 16'h0000);
      chk("clear_running", {15'd0, running}, 16'd0);
      cycles(3);
      chk("idle_hold", disp, 16'h0000);

      // pause keeps the fractional second
      pulse_start();
      cycles(37);
      chk("pre_pause", disp, 16'h0009);
      pulse_start();
      chk("pause_running", {15'd0, running}, 16'd0);
      cycles(10);
      chk("pause_hold", disp, 16'h0009);
      chk("pause_running2", {15'd0, running}, 16'd0);
      pulse_start();
      chk("resume_running", {15'd0, running}, 16'd1);
      cycles(2);
      chk("resume_r2", disp, 16'h0009);
      cycles(1);
      chk("resume_r3", disp, 16'h0010);

      // lap freeze and release
      pulse_clear();
      pulse_start();
      cycles(13);
      chk("lap_pre", disp, 16'h0003);
      pulse_lap();
      chk("lap_frozen", {15'd0, frozen}, 16'd1);
      chk("lap_snap", disp, 16'h0003);
      cycles(11);
      chk("lap_hold", disp, 16'h0003);
      chk("lap_frozen2", {15'd0, frozen}, 16'd1);
      pulse_lap();
      chk("lap_release", {15'd0, frozen}, 16'd0);
      chk("lap_follow", disp, 16'h0006);
      pulse_start();
      chk("pause_again", {15'd0, running}, 16'd0);
      pulse_lap();
      chk("lap_in_pause", {15'd0, frozen}, 16'd0);
      chk("lap_pause_disp", disp, 16'h0006);

      // start_stop + clear + lap together in RUN: clear wins
      pulse_start();
      chk("rerun", {15'd0, running}, 16'd1);
      start_stop = 1'b1;
      clear = 1'b1;
      lap = 1'b1;
      @(negedge clk);
      start_stop = 1'b0;
      clear = 1'b0;
      lap = 1'b0;
      chk("both_running", {15'd0, running}, 16'd0);
      chk("both_frozen", {15'd0, frozen}, 16'd0);
      chk("both_disp", disp, 16'h0000);
      chk("both_wrap", {15'd0, wrap}, 16'd0);
      cycles(6);
      chk("both_idle", disp, 16'h0000);

      // rollover from 59:59
      pulse_start();
      cycles(14397);
      chk("at_5959", disp, 16'h5959);
      chk("pre_wrap", {15'd0, wrap}, 16'd0);
      cycles(3);
      chk("wrap_pulse", {15'd0, wrap}, 16'd1);
      chk("wrap_running", {15'd0, running}, 16'd1);
      chk("wrap_disp_lag", disp, 16'h5959);
      cycles(1);
      chk("wrap_one_cycle", {15'd0, wrap}, 16'd0);
      chk("wrap_disp", disp, 16'h0000);
      chk("wrap_running2", {15'd0, running}, 16'd1);
      cycles(4);
      chk("wrap_continue", disp, 16'h0001);

      // reset at 12:34 while frozen; inputs in the reset cycle are discarded
      pulse_clear();
      pulse_start();
      cycles(3017);
      chk("at_1234", disp, 16'h1234);
      pulse_lap();
      cycles(2);
      chk("frozen_1234", disp, 16'h1234);
      rst_n = 1'b0;
      start_stop = 1'b1;
      lap = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      start_stop = 1'b0;
      lap = 1'b0;
      chk("mid_rst_disp", disp, 16'h0000);
      chk("mid_rst_running", {15'd0, running}, 16'd0);
      chk("mid_rst_frozen", {15'd0, frozen}, 16'd0);
      chk("mid_rst_wrap", {15'd0, wrap}, 16'd0);
      cycles(3);
      chk("post_rst_idle", {disp[14:0], running}, 16'd0);
      pulse_start();
      chk("restart_running", {15'd0, running}, 16'd1);
      cycles(5);
      chk("restart_disp", disp, 16'h0001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
